// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings, default widths
// and the bundled hazard control word used by the decoder and later stages.
package hazard_controller_pkg;

  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH      = 2'b10;
  localparam logic [1:0] ST_MEM_WAIT   = 2'b11;

  localparam int HZ_AWIDTH = 5;
  localparam int HZ_CWIDTH = 16;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_bubble;
    logic idex_stall;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE       = 6'b000000;
  localparam hz_ctrl_t CTRL_FREEZE     = 6'b110100;
  localparam hz_ctrl_t CTRL_LOAD_USE   = 6'b111000;
  localparam hz_ctrl_t CTRL_FLUSH_BOTH = 6'b000011;
  localparam hz_ctrl_t CTRL_FLUSH_IFID = 6'b000010;

endpackage

// File: rtl/hazard_controller_stall_counter.sv
// Saturating stall-cycle counter; a clear wins over a same-cycle increment.
module hz_stall_counter #(
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [CWIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CWIDTH'(1);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory
// freezes from a 4-state FSM with combinational (Mealy) control outputs.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int AWIDTH = HZ_AWIDTH,
  parameter int CWIDTH = HZ_CWIDTH
) (
  input  logic              hz_clk,
  input  logic              hz_rst,
  input  logic              hz_i_id_valid,
  input  logic [AWIDTH-1:0] hz_i_id_rs,
  input  logic [AWIDTH-1:0] hz_i_id_rt,
  input  logic              hz_i_id_uses_rt,
  input  logic              hz_i_ex_memread,
  input  logic [AWIDTH-1:0] hz_i_ex_rd,
  input  logic              hz_i_branch_taken,
  input  logic              hz_i_mem_busy,
  input  logic              hz_i_cnt_clr,
  output logic              hz_o_pc_stall,
  output logic              hz_o_ifid_stall,
  output logic              hz_o_idex_bubble,
  output logic              hz_o_idex_stall,
  output logic              hz_o_ifid_flush,
  output logic              hz_o_idex_flush,
  output logic [1:0]        hz_o_state,
  output logic [CWIDTH-1:0] hz_o_stall_cnt
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  hz_ctrl_t   ctrl;
  logic       load_use;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = hz_i_id_valid && hz_i_ex_memread && (hz_i_ex_rd != '0) &&
                    ((hz_i_ex_rd == hz_i_id_rs) ||
                     (hz_i_id_uses_rt && (hz_i_ex_rd == hz_i_id_rt)));

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_NONE;
    case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (hz_i_mem_busy) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (hz_i_branch_taken) begin
          ctrl    = CTRL_FLUSH_BOTH;
          state_d = ST_FLUSH;
        end else if (load_use && (state_q == ST_RUN)) begin
          // EX holds the bubble in LOAD_STALL, so only RUN can raise a hazard
          ctrl    = CTRL_LOAD_USE;
          state_d = ST_LOAD_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (hz_i_mem_busy) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else begin
          ctrl    = CTRL_FLUSH_IFID;
          state_d = ST_RUN;
        end
      end
      default: begin
        if (hz_i_mem_busy) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
    // Control must drop the instant reset asserts, not at the next edge
    if (hz_rst)
      ctrl = CTRL_NONE;
  end

  always_ff @(posedge hz_clk or posedge hz_rst) begin
    if (hz_rst)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  assign hz_o_pc_stall    = ctrl.pc_stall;
  assign hz_o_ifid_stall  = ctrl.ifid_stall;
  assign hz_o_idex_bubble = ctrl.idex_bubble;
  assign hz_o_idex_stall  = ctrl.idex_stall;
  assign hz_o_ifid_flush  = ctrl.ifid_flush;
  assign hz_o_idex_flush  = ctrl.idex_flush;
  assign hz_o_state       = state_q;

  hz_stall_counter #(
    .CWIDTH (CWIDTH)
  ) u_stall_counter (
    .clk   (hz_clk),
    .rst   (hz_rst),
    .inc   (ctrl.pc_stall),
    .clr   (hz_i_cnt_clr),
    .count (hz_o_stall_cnt)
  );

endmodule
